// File: rtl/stego_img_pkg.sv
// Shared definitions for the stego image path (embedder, write controller,
// BMP writer).
//   wctrl_state_t : write-controller FSM states
//   PAIR_W        : width of one RGB888 pixel pair {R1,G1,B1,R0,G0,B0}
//   *_LSB         : byte-lane offsets of each colour byte inside a pair
//   cnt_w()       : counter width for a count range, never below 1 bit
package stego_img_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } wctrl_state_t;

  localparam int PAIR_W = 48;
  localparam int BYTE_W = 8;

  // Odd pixel occupies the upper half, even pixel the lower half.
  localparam int B0_LSB = 0;
  localparam int G0_LSB = 8;
  localparam int R0_LSB = 16;
  localparam int B1_LSB = 24;
  localparam int G1_LSB = 32;
  localparam int R1_LSB = 40;

  // $clog2(n) with a floor of one bit so degenerate ranges still give a
  // legal vector width.
  function automatic int cnt_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/line_gap_timer.sv
// Inter-row blanking timer.
//   clk, rst : clock, synchronous active-high reset
//   clr      : force the count to zero (highest priority)
//   load     : arm the timer for a fresh gap of LINE_GAP cycles
//   en       : count down one step (held at zero once there)
//   expired  : count is zero, i.e. the current gap cycle is the last one
// Loading LINE_GAP-1 makes the owning FSM spend exactly LINE_GAP cycles in
// its gap state when it leaves on the first cycle that sees expired.
module line_gap_timer
  import stego_img_pkg::*;
#(
  parameter  int LINE_GAP = 2,
  localparam int CNT_W    = cnt_w(LINE_GAP + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic load,
  input  logic en,
  output logic expired
);

  localparam logic [CNT_W-1:0] LOAD_VAL =
    (LINE_GAP > 0) ? CNT_W'(LINE_GAP - 1) : '0;

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (load) begin
      cnt_d = LOAD_VAL;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = (cnt_q == '0);

endmodule

// File: rtl/stego_write_ctrl.sv
// Write sequencing controller in front of the BMP writer.
// Accepts stego-embedded RGB888 pixel pairs and issues one registered
// hsync strobe + pair bytes per accepted pair, tracking row/column and
// inserting LINE_GAP idle cycles between rows. frame_done pulses once,
// the cycle after the final hsync.
//   HCLK, HRESET          : clock, synchronous active-high reset
//   start, abort          : frame begin (IDLE only) / frame cancel
//   in_valid, in_ready,
//   in_pair               : upstream pair handshake
//   hsync, DATA_WRITE_*   : writer strobe and registered pair bytes
//   wr_row, wr_col        : position of the pair carried by hsync
//   busy, frame_done      : frame in progress / frame finished pulse
//   dbg_state             : current FSM state
//
// Handshake: a pair moves on every rising edge where in_valid && in_ready.
// in_ready depends on the FSM state only (high exactly in RUN), so the
// upstream may hold in_valid and data stable for as long as it likes and
// there is no combinational path from in_valid back to in_ready.
module stego_write_ctrl
  import stego_img_pkg::*;
#(
  parameter  int WIDTH    = 768,
  parameter  int HEIGHT   = 512,
  parameter  int LINE_GAP = 2,
  localparam int ROW_W    = cnt_w(HEIGHT),
  localparam int COL_W    = cnt_w(WIDTH / 2)
) (
  input  logic              HCLK,
  input  logic              HRESET,
  input  logic              start,
  input  logic              abort,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PAIR_W-1:0] in_pair,
  output logic              hsync,
  output logic [7:0]        DATA_WRITE_R0,
  output logic [7:0]        DATA_WRITE_G0,
  output logic [7:0]        DATA_WRITE_B0,
  output logic [7:0]        DATA_WRITE_R1,
  output logic [7:0]        DATA_WRITE_G1,
  output logic [7:0]        DATA_WRITE_B1,
  output logic [ROW_W-1:0]  wr_row,
  output logic [COL_W-1:0]  wr_col,
  output logic              busy,
  output logic              frame_done,
  output wctrl_state_t      dbg_state
);

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(WIDTH / 2 - 1);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(HEIGHT - 1);

  wctrl_state_t      state_q, state_d;
  logic [COL_W-1:0]  col_q, col_d;
  logic [ROW_W-1:0]  row_q, row_d;
  logic              hsync_q, hsync_d;
  logic [PAIR_W-1:0] pair_q, pair_d;
  logic [ROW_W-1:0]  wr_row_q, wr_row_d;
  logic [COL_W-1:0]  wr_col_q, wr_col_d;
  logic              frame_done_q, frame_done_d;

  logic gap_clr, gap_load, gap_en, gap_expired;
  logic xfer;

  line_gap_timer #(.LINE_GAP(LINE_GAP)) u_gap (
    .clk     (HCLK),
    .rst     (HRESET),
    .clr     (gap_clr),
    .load    (gap_load),
    .en      (gap_en),
    .expired (gap_expired)
  );

  assign in_ready = (state_q == ST_RUN);
  assign xfer     = in_valid && in_ready;

  always_comb begin
    state_d      = state_q;
    col_d        = col_q;
    row_d        = row_q;
    hsync_d      = 1'b0;
    pair_d       = pair_q;
    wr_row_d     = wr_row_q;
    wr_col_d     = wr_col_q;
    frame_done_d = 1'b0;
    gap_clr      = 1'b0;
    gap_load     = 1'b0;
    gap_en       = 1'b0;

    // Output stage: capture the pair and its position on every transfer.
    // This is independent of abort, so a pair accepted in the abort cycle
    // still reaches the writer.
    if (xfer) begin
      hsync_d  = 1'b1;
      pair_d   = in_pair;
      wr_row_d = row_q;
      wr_col_d = col_q;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          state_d = ST_RUN;
          col_d   = '0;
          row_d   = '0;
          gap_clr = 1'b1;
        end
      end
      ST_RUN: begin
        if (xfer) begin
          if (col_q == LAST_COL) begin
            col_d = '0;
            if (row_q == LAST_ROW) begin
              row_d   = '0;
              state_d = ST_DONE;
            end else begin
              row_d = row_q + 1'b1;
              if (LINE_GAP > 0) begin
                state_d  = ST_GAP;
                gap_load = 1'b1;
              end
            end
          end else begin
            col_d = col_q + 1'b1;
          end
        end
      end
      ST_GAP: begin
        gap_en = 1'b1;
        if (gap_expired) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        // Registered, so the pulse lands one cycle after the final hsync.
        frame_done_d = 1'b1;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

    // Abort wins over every in-frame transition, including the DONE pulse.
    if (abort && (state_q != ST_IDLE)) begin
      state_d      = ST_IDLE;
      col_d        = '0;
      row_d        = '0;
      frame_done_d = 1'b0;
      gap_clr      = 1'b1;
      gap_load     = 1'b0;
    end
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q      <= ST_IDLE;
      col_q        <= '0;
      row_q        <= '0;
      hsync_q      <= 1'b0;
      pair_q       <= '0;
      wr_row_q     <= '0;
      wr_col_q     <= '0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      col_q        <= col_d;
      row_q        <= row_d;
      hsync_q      <= hsync_d;
      pair_q       <= pair_d;
      wr_row_q     <= wr_row_d;
      wr_col_q     <= wr_col_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign hsync         = hsync_q;
  assign wr_row        = wr_row_q;
  assign wr_col        = wr_col_q;
  assign frame_done    = frame_done_q;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign dbg_state     = state_q;

  assign DATA_WRITE_R0 = pair_q[R0_LSB +: BYTE_W];
  assign DATA_WRITE_G0 = pair_q[G0_LSB +: BYTE_W];
  assign DATA_WRITE_B0 = pair_q[B0_LSB +: BYTE_W];
  assign DATA_WRITE_R1 = pair_q[R1_LSB +: BYTE_W];
  assign DATA_WRITE_G1 = pair_q[G1_LSB +: BYTE_W];
  assign DATA_WRITE_B1 = pair_q[B1_LSB +: BYTE_W];

endmodule

// File: tb/tb_stego_write_ctrl.sv
// Bench for stego_write_ctrl with WIDTH=4, HEIGHT=2, LINE_GAP=2.
// A frame-level model (accepted-pair count, remaining gap cycles, done flag)
// predicts the outputs after every edge; a negedge process compares them.
// Directed scenarios add hand-computed literal checks.
module tb_stego_write_ctrl;
  import stego_img_pkg::*;

  localparam int W     = 4;
  localparam int H     = 2;
  localparam int G     = 2;
  localparam int NP    = W / 2;
  localparam int TOTAL = W * H / 2;
  localparam int RW    = cnt_w(H);
  localparam int CW    = cnt_w(W / 2);

  // ---------------- clock / reset / DUT ----------------
  logic              HCLK = 1'b0;
  logic              HRESET = 1'b1;
  logic              start = 1'b0;
  logic              abort = 1'b0;
  logic              in_valid = 1'b0;
  logic [PAIR_W-1:0] in_pair = '0;
  logic              in_ready, hsync, busy, frame_done;
  logic [7:0]        r0, g0, b0, r1, g1, b1;
  logic [RW-1:0]     wr_row;
  logic [CW-1:0]     wr_col;
  wctrl_state_t      dbg_state;

  always #5 HCLK = ~HCLK;

  stego_write_ctrl #(.WIDTH(W), .HEIGHT(H), .LINE_GAP(G)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .start         (start),
    .abort         (abort),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_pair       (in_pair),
    .hsync         (hsync),
    .DATA_WRITE_R0 (r0),
    .DATA_WRITE_G0 (g0),
    .DATA_WRITE_B0 (b0),
    .DATA_WRITE_R1 (r1),
    .DATA_WRITE_G1 (g1),
    .DATA_WRITE_B1 (b1),
    .wr_row        (wr_row),
    .wr_col        (wr_col),
    .busy          (busy),
    .frame_done    (frame_done),
    .dbg_state     (dbg_state)
  );

  wire [PAIR_W-1:0] dut_pair = {r1, g1, b1, r0, g0, b0};

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  bit                m_idle = 1'b1;
  int                m_gap = 0;
  bit                m_fin = 1'b0;
  int                m_pairs = 0;
  logic              exp_hsync = 1'b0;
  logic              exp_fd = 1'b0;
  logic [PAIR_W-1:0] exp_data = '0;
  int                exp_row = 0;
  int                exp_col = 0;
  logic [PAIR_W-1:0] exp_q[$];
  bit                chk_en = 1'b0;

  task automatic model_step();
    bit was_idle, rdy;
    if (HRESET) begin
      m_idle = 1'b1; m_gap = 0; m_fin = 1'b0; m_pairs = 0;
      exp_hsync = 1'b0; exp_fd = 1'b0; exp_data = '0;
      exp_row = 0; exp_col = 0;
      exp_q.delete();
      chk_en = 1'b1;
      return;
    end
    was_idle  = m_idle;
    rdy       = !m_idle && (m_gap == 0) && !m_fin;
    exp_hsync = 1'b0;
    exp_fd    = 1'b0;
    if (rdy && in_valid) begin
      exp_hsync = 1'b1;
      exp_data  = in_pair;
      exp_q.push_back(in_pair);
      exp_row   = m_pairs / NP;
      exp_col   = m_pairs % NP;
      m_pairs++;
      if (m_pairs == TOTAL) m_fin = 1'b1;
      else if (m_pairs % NP == 0) m_gap = G;
    end else if (!m_idle && m_gap > 0) begin
      m_gap--;
    end else if (m_fin) begin
      exp_fd = 1'b1;
      m_fin  = 1'b0;
      m_idle = 1'b1;
    end
    if (was_idle && start && !abort) begin
      m_idle = 1'b0; m_pairs = 0; m_gap = 0; m_fin = 1'b0;
    end
    if (!was_idle && abort) begin
      m_idle = 1'b1; m_pairs = 0; m_gap = 0; m_fin = 1'b0;
      exp_fd = 1'b0;
    end
  endtask

  always @(posedge HCLK) model_step();

  // ---------------- scoreboard / compare ----------------
  always @(negedge HCLK) begin
    if (chk_en) begin
      chk("hsync", hsync, exp_hsync);
      chk("in_ready", in_ready, !m_idle && (m_gap == 0) && !m_fin);
      chk("busy", busy, !m_idle && !m_fin);
      chk("frame_done", frame_done, exp_fd);
      chk("data_hold", dut_pair, exp_data);
      if (exp_hsync) begin
        chk("wr_row", wr_row, exp_row);
        chk("wr_col", wr_col, exp_col);
      end
      if (hsync) begin
        if (exp_q.size() == 0) chk("sb_unexpected_hsync", 1'b1, 1'b0);
        else chk("sb_pair", dut_pair, exp_q.pop_front());
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Advance one edge; inputs are driven and literals sampled 3 ns later.
  task automatic cyc();
    @(posedge HCLK);
    #3;
  endtask

  function automatic logic [PAIR_W-1:0] rnd_pair();
    return {16'($urandom), 32'($urandom)};
  endfunction

  task automatic run_frame(input string tag, input bit alt_valid, input bit hold_start);
    int n_hs, n_fd, post;
    n_hs = 0; n_fd = 0; post = -1;
    start = 1'b1; in_valid = 1'b1; in_pair = rnd_pair();
    for (int i = 0; i < 60 && post != 0; i++) begin
      cyc();
      if (!hold_start) start = 1'b0;
      if (hsync) n_hs++;
      if (frame_done) begin
        n_fd++;
        start = 1'b0;
        post = 4;
      end else if (post > 0) begin
        post--;
      end
      in_valid = alt_valid ? ~in_valid : 1'b1;
      in_pair  = rnd_pair();
    end
    start = 1'b0; in_valid = 1'b0;
    chk({tag, "_hsync_count"}, n_hs, TOTAL);
    chk({tag, "_done_count"}, n_fd, 1);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    bit hs_e[8]  = '{1, 1, 0, 0, 1, 1, 0, 0};
    bit rdy_e[8] = '{1, 0, 0, 1, 1, 0, 0, 0};
    bit fd_e[8]  = '{0, 0, 0, 0, 0, 0, 1, 0};
    int cnt;

    // Reset with in_valid asserted
    HRESET = 1'b1; in_valid = 1'b1;
    cyc(); cyc();
    chk("rst_hsync", hsync, 0);
    chk("rst_ready", in_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", frame_done, 0);
    chk("rst_data", dut_pair, 0);
    chk("rst_row", wr_row, 0);
    chk("rst_col", wr_col, 0);
    HRESET = 1'b0; in_valid = 1'b0;
    cyc();

    // Full frame, start sampled at E0, in_valid held high
    start = 1'b1; in_valid = 1'b1; in_pair = 48'h1122_3344_5566;
    cyc();
    start = 1'b0;
    chk("ff_ready_e0", in_ready, 1);
    for (int k = 1; k <= 8; k++) begin
      cyc();
      chk($sformatf("ff_hsync_e%0d", k), hsync, hs_e[k-1]);
      chk($sformatf("ff_ready_e%0d", k), in_ready, rdy_e[k-1]);
      chk($sformatf("ff_done_e%0d", k), frame_done, fd_e[k-1]);
      if (hs_e[k-1]) begin
        chk($sformatf("ff_row_e%0d", k), wr_row, (k >= 5) ? 1 : 0);
        chk($sformatf("ff_col_e%0d", k), wr_col, (k == 2 || k == 6) ? 1 : 0);
      end
      if (k == 1) begin
        chk("ff_r1", r1, 8'h11); chk("ff_g1", g1, 8'h22); chk("ff_b1", b1, 8'h33);
        chk("ff_r0", r0, 8'h44); chk("ff_g0", g0, 8'h55); chk("ff_b0", b0, 8'h66);
      end
      if (k == 7) chk("ff_busy_e7", busy, 0);
      in_pair = rnd_pair();
    end
    in_valid = 1'b0;
    cyc();

    // Backpressure: in_valid alternates
    run_frame("bp", 1'b1, 1'b0);

    // start held through RUN, GAP and DONE: exactly one frame
    run_frame("hold_start", 1'b0, 1'b1);

    // Abort on the first transfer of row 1 (edge E5)
    start = 1'b1; in_valid = 1'b1; in_pair = rnd_pair();
    cyc();
    start = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      cyc();
      in_pair = rnd_pair();
    end
    abort = 1'b1;
    cyc();
    abort = 1'b0;
    chk("ab_hsync", hsync, 1);
    chk("ab_row", wr_row, 1);
    chk("ab_col", wr_col, 0);
    chk("ab_busy", busy, 0);
    chk("ab_ready", in_ready, 0);
    cnt = 0;
    for (int k = 0; k < 6; k++) begin
      cyc();
      if (frame_done || hsync) cnt++;
    end
    chk("ab_quiet_after", cnt, 0);
    start = 1'b1;
    cyc();
    start = 1'b0;
    cyc();
    chk("ab_restart_hsync", hsync, 1);
    chk("ab_restart_row", wr_row, 0);
    chk("ab_restart_col", wr_col, 0);
    for (int k = 0; k < 10; k++) cyc();
    in_valid = 1'b0;
    cyc();

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; in_valid = 1'b1;
    cyc();
    start = 1'b0; abort = 1'b0;
    chk("sa_busy", busy, 0);
    chk("sa_ready", in_ready, 0);
    cyc();
    chk("sa_hsync", hsync, 0);
    in_valid = 1'b0;

    // Reset while in GAP
    start = 1'b1; in_valid = 1'b1;
    cyc();
    start = 1'b0;
    cyc(); cyc();
    chk("mr_in_gap", busy && !in_ready, 1);
    HRESET = 1'b1;
    cyc();
    chk("mr_hsync", hsync, 0);
    chk("mr_ready", in_ready, 0);
    chk("mr_busy", busy, 0);
    chk("mr_data", dut_pair, 0);
    chk("mr_row", wr_row, 0);
    chk("mr_col", wr_col, 0);
    HRESET = 1'b0; in_valid = 1'b0;
    cyc();
    run_frame("mr_new", 1'b0, 1'b0);

    // Randomised traffic against the model
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 9) == 0);
      abort    = ($urandom_range(0, 59) == 0);
      in_valid = ($urandom_range(0, 3) != 0);
      HRESET   = ($urandom_range(0, 399) == 0);
      in_pair  = rnd_pair();
      cyc();
    end
    start = 1'b0; abort = 1'b0; in_valid = 1'b0; HRESET = 1'b0;
    for (int k = 0; k < 10; k++) cyc();
    chk("sb_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule
